// File: rtl/blink_game_if.sv
// Player-facing signal bundle for blink_game_core: controls in, LED/score/status out.
interface blink_game_if #(
    parameter int NUM_LEDS = 16
);
    logic                start;
    logic                btn;
    logic [NUM_LEDS-1:0] sw;
    logic [NUM_LEDS-1:0] led;
    logic [6:0]          score;
    logic [2:0]          lives;
    logic                playing;
    logic                win;
    logic                lose;
    logic                step;

    modport master (
        output start, btn, sw,
        input  led, score, lives, playing, win, lose, step
    );

    modport slave (
        input  start, btn, sw,
        output led, score, lives, playing, win, lose, step
    );
endinterface

// File: rtl/blink_game_core.sv
// LED-blink game engine: a moving lit LED, match it on the switches and press fire.
// Optional BLINK_LFSR_EN: pseudo-random LED jumps from an 8-bit LFSR instead of walking.
//
//   state  | meaning
//   IDLE   | after reset, LEDs dark, waiting for start
//   PLAY   | LED advancing, presses judged
//   WIN    | target score reached, all LEDs lit
//   LOSE   | out of lives, LEDs dark
module blink_game_core #(
    parameter int NUM_LEDS  = 16,
    parameter int WIN_SCORE = 9,
    parameter int LIVES     = 3,
    parameter int BASE_DIV  = 50000000,
    parameter int DIV_STEP  = 2500000,
    parameter int MIN_DIV   = 5000000
) (
    input logic         clk,
    input logic         reset,
    blink_game_if.slave bus
);
    localparam int PW   = $clog2(BASE_DIV + 1);
    localparam int POSW = $clog2(NUM_LEDS);
    localparam logic [NUM_LEDS-1:0] LED_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WIN, S_LOSE} state_t;

    state_t              state_q, state_d;
    logic [POSW-1:0]     pos_q, pos_d;
    logic [PW-1:0]       prescaler_q, prescaler_d;
    logic [PW-1:0]       cur_div_q, cur_div_d;
    logic [PW-1:0]       period_q, period_d;
    logic [6:0]          score_q, score_d;
    logic [2:0]          lives_q, lives_d;
    logic                armed_q, armed_d;
    logic                btn_q, btn_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                step_q, step_d;
    logic                playing_q, playing_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;

    logic                press;
    logic                tc;
    logic [PW-1:0]       period_dec;
    logic [POSW-1:0]     next_pos;
    logic [POSW-1:0]     walk_pos;

`ifdef BLINK_LFSR_EN
    logic [7:0]          lfsr_q, lfsr_d;
    logic [POSW-1:0]     rnd_pos;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        prescaler_d = prescaler_q;
        cur_div_d   = cur_div_q;
        period_d    = period_q;
        score_d     = score_q;
        lives_d     = lives_q;
        armed_d     = armed_q;
        btn_d       = bus.btn;

        press = bus.btn & ~btn_q;
        tc    = (state_q == S_PLAY) && (prescaler_q == cur_div_q - PW'(1));

        if (32'(period_q) >= MIN_DIV + DIV_STEP) period_dec = period_q - PW'(DIV_STEP);
        else                                     period_dec = PW'(MIN_DIV);

        walk_pos = (pos_q == POSW'(NUM_LEDS - 1)) ? '0 : pos_q + POSW'(1);
`ifdef BLINK_LFSR_EN
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        rnd_pos  = POSW'(int'({24'd0, lfsr_q}) % NUM_LEDS);
        next_pos = (rnd_pos == pos_q) ? walk_pos : rnd_pos;
`else
        next_pos = walk_pos;
`endif

        case (state_q)
            S_PLAY: begin
                if (press && armed_q) begin
                    armed_d = 1'b0;
                    if (bus.sw == led_q) begin
                        score_d  = score_q + 7'd1;
                        period_d = period_dec;
                        if (score_d == 7'(WIN_SCORE)) state_d = S_WIN;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) state_d = S_LOSE;
                    end
                end
                // A step re-arms after any same-cycle press so the new position gets its own attempt.
                if (tc) begin
                    prescaler_d = '0;
                    cur_div_d   = period_d;
                    armed_d     = 1'b1;
                    pos_d       = next_pos;
                end else begin
                    prescaler_d = prescaler_q + PW'(1);
                end
            end
            default: begin
                if (bus.start) begin
                    state_d     = S_PLAY;
                    pos_d       = '0;
                    score_d     = '0;
                    lives_d     = 3'(LIVES);
                    period_d    = PW'(BASE_DIV);
                    cur_div_d   = PW'(BASE_DIV);
                    prescaler_d = '0;
                    armed_d     = 1'b1;
                end
            end
        endcase

        case (state_d)
            S_PLAY:  led_d = LED_ONE << pos_d;
            S_WIN:   led_d = '1;
            default: led_d = '0;
        endcase

        // Registered step lands in the terminal-count cycle; the LED moves on the next one.
        step_d    = (state_d == S_PLAY) && (prescaler_d == cur_div_d - PW'(1));
        playing_d = (state_d == S_PLAY);
        win_d     = (state_d == S_WIN);
        lose_d    = (state_d == S_LOSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            prescaler_q <= '0;
            cur_div_q   <= PW'(BASE_DIV);
            period_q    <= PW'(BASE_DIV);
            score_q     <= '0;
            lives_q     <= 3'(LIVES);
            armed_q     <= 1'b0;
            btn_q       <= 1'b0;
            led_q       <= '0;
            step_q      <= 1'b0;
            playing_q   <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
`ifdef BLINK_LFSR_EN
            lfsr_q      <= 8'hA5;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            prescaler_q <= prescaler_d;
            cur_div_q   <= cur_div_d;
            period_q    <= period_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            armed_q     <= armed_d;
            btn_q       <= btn_d;
            led_q       <= led_d;
            step_q      <= step_d;
            playing_q   <= playing_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
`ifdef BLINK_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign bus.led     = led_q;
    assign bus.score   = score_q;
    assign bus.lives   = lives_q;
    assign bus.playing = playing_q;
    assign bus.win     = win_q;
    assign bus.lose    = lose_q;
    assign bus.step    = step_q;
endmodule

// File: tb/tb_blink_game_core.sv
// Bench for blink_game_core: directed game scenarios then random play, checked against a game-rule model.
module tb_blink_game_core;
    localparam int NL = 4, WS = 3, LV = 2, BD = 8, DS = 2, MD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    blink_game_if #(.NUM_LEDS(NL)) bif();

    blink_game_core #(
        .NUM_LEDS(NL), .WIN_SCORE(WS), .LIVES(LV),
        .BASE_DIV(BD), .DIV_STEP(DS), .MIN_DIV(MD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Model: mode 0 idle, 1 play, 2 win, 3 lose; cnt = cycles into the current step interval of length len.
    int m_mode, m_pos, m_cnt, m_len, m_period, m_score, m_lives, m_lfsr;
    bit m_armed, m_btn_prev;

    function automatic int exp_led();
        if (m_mode == 1) return 1 << m_pos;
        if (m_mode == 2) return (1 << NL) - 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_update();
        bit press, boundary;
        int old_lfsr, fb, r;
        if (reset) begin
            m_mode = 0; m_pos = 0; m_cnt = 0; m_len = BD; m_period = BD;
            m_score = 0; m_lives = LV; m_armed = 0; m_btn_prev = 0; m_lfsr = 8'hA5;
            return;
        end
        press      = bif.btn && !m_btn_prev;
        m_btn_prev = bif.btn;
        old_lfsr   = m_lfsr;
        fb         = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr     = ((m_lfsr << 1) | fb) & 255;
        if (m_mode != 1) begin
            if (bif.start) begin
                m_mode = 1; m_pos = 0; m_score = 0; m_lives = LV;
                m_period = BD; m_len = BD; m_cnt = 0; m_armed = 1;
            end
        end else begin
            boundary = (m_cnt == m_len - 1);
            if (press && m_armed) begin
                m_armed = 0;
                if (int'(bif.sw) == (1 << m_pos)) begin
                    m_score++;
                    m_period = (m_period - DS < MD) ? MD : m_period - DS;
                    if (m_score == WS) m_mode = 2;
                end else begin
                    m_lives--;
                    if (m_lives == 0) m_mode = 3;
                end
            end
            if (boundary) begin
                m_cnt = 0; m_len = m_period; m_armed = 1;
`ifdef BLINK_LFSR_EN
                r     = old_lfsr % NL;
                m_pos = (r == m_pos) ? (m_pos + 1) % NL : r;
`else
                r     = old_lfsr;
                m_pos = (m_pos + 1) % NL;
`endif
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("led",     int'(bif.led),     exp_led());
        chk("score",   int'(bif.score),   m_score);
        chk("lives",   int'(bif.lives),   m_lives);
        chk("playing", int'(bif.playing), int'(m_mode == 1));
        chk("win",     int'(bif.win),     int'(m_mode == 2));
        chk("lose",    int'(bif.lose),    int'(m_mode == 3));
        chk("step",    int'(bif.step),    int'(m_mode == 1 && m_cnt == m_len - 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pulse_start();
        bif.start = 1'b1; tick(); bif.start = 1'b0;
    endtask

    task automatic press_once(input bit match);
        bif.sw  = match ? NL'(exp_led()) : 4'b0011;
        bif.btn = 1'b1; tick();
        bif.btn = 1'b0; tick();
    endtask

    initial begin
        bit found;
        reset = 1'b1; bif.start = 1'b0; bif.btn = 1'b0; bif.sw = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Walk and step cadence
        pulse_start();
        chk("start_led", int'(bif.led), 1);
        repeat (40) tick();

        // Hits shorten the period; holding the button counts once; third hit wins
        press_once(1'b1);
        repeat (10) tick();
        bif.sw = NL'(exp_led()); bif.btn = 1'b1;
        repeat (20) tick();
        bif.btn = 1'b0; tick();
        chk("hold_score", int'(bif.score), 2);
        repeat (10) tick();
        press_once(1'b1);
        chk("win_flag", int'(bif.win), 1);
        chk("win_led", int'(bif.led), 15);
        press_once(1'b1);
        press_once(1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("reset_led", int'(bif.led), 0);

        // Two misses lose, then restart
        pulse_start();
        press_once(1'b0);
        repeat (10) tick();
        press_once(1'b0);
        chk("lose_flag", int'(bif.lose), 1);
        repeat (5) tick();
        pulse_start();
        chk("restart_lives", int'(bif.lives), LV);

        // Press coinciding with a step, then a press on the new position
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_mode == 1 && m_cnt == m_len - 1) found = 1'b1;
            else tick();
        end
        chk("step_wait", int'(found), 1);
        bif.sw = NL'(exp_led()); bif.btn = 1'b1; tick();
        bif.btn = 1'b0; tick();
        bif.sw = NL'(exp_led()); bif.btn = 1'b1; tick();
        bif.btn = 1'b0; tick();
        chk("step_hit_score", int'(bif.score), 2);

        // Random play
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 399) == 0);
            bif.start = ($urandom_range(0, 59) == 0);
            bif.btn   = ($urandom_range(0, 3) == 0);
            bif.sw    = ($urandom_range(0, 2) != 0) ? NL'(exp_led()) : NL'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
